// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - in-order instruction queue with LD/ST vs arithmetic RS steering
// Heads are issued in program order; reserved opcodes are dropped with a one-cycle illegal pulse.
module issue_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [15:0]      in_instr,
  output logic             in_ready,
  input  logic             asrs_full,
  input  logic             ars_full,
  output logic             asrs_we,
  output logic             ars_we,
  output logic [2:0]       opcode,
  output logic [2:0]       rd,
  output logic [2:0]       rs,
  output logic [6:0]       offset,
  output logic             illegal,
  output logic [PTR_W:0]   count,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             illegal_q;

  logic [15:0]      head;
  logic             head_is_ldst;
  logic             head_is_arith;
  logic             head_is_rsvd;
  logic             discard;
  logic             push;
  logic             pop;

  assign head   = mem[rd_ptr];
  assign opcode = head[15:13];
  assign rd     = head[12:10];
  assign rs     = head[9:7];
  assign offset = head[6:0];

  assign head_is_arith = ~opcode[2];
  assign head_is_ldst  = opcode[2] & ~opcode[1];
  assign head_is_rsvd  = opcode[2] & opcode[1];

  assign empty    = (count == '0);
  assign in_ready = (count != FULL_CNT);

  assign asrs_we = ~empty & ~flush & head_is_ldst  & ~asrs_full;
  assign ars_we  = ~empty & ~flush & head_is_arith & ~ars_full;
  assign discard = ~empty & ~flush & head_is_rsvd;

  // in_ready reflects the pre-pop count, so a full queue never accepts even while popping
  assign push = in_valid & in_ready & ~flush;
  assign pop  = asrs_we | ars_we | discard;

  assign illegal = illegal_q;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= discard;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
